// File: rtl/hist2d_accum_stream.sv
// hist2d_accum_stream: 2D IQ histogram with saturating single-RAM bin accumulation and raster readout
module hist2d_accum_stream #(
  parameter int I_BINS_MAX    = 16,
  parameter int Q_BINS_MAX    = 16,
  parameter int COORD_W       = 8,
  parameter int CNT_W         = 16,
  parameter int CLEAR_ON_READ = 1
) (
  input  logic               clk100,
  input  logic               rst,
  input  logic               data_in,
  input  logic [COORD_W-1:0] i_bin_coord,
  input  logic [COORD_W-1:0] q_bin_coord,
  input  logic [COORD_W-1:0] i_bin_num,
  input  logic [COORD_W-1:0] q_bin_num,
  input  logic               start_data_out,
  output logic               data_out,
  output logic [CNT_W-1:0]   bin_val,
  output logic [COORD_W-1:0] i_bin_out,
  output logic [COORD_W-1:0] q_bin_out,
  output logic               last_out,
  output logic               busy,
  output logic [15:0]        drop_cnt,
  output logic               sat_flag
);
  localparam int N = I_BINS_MAX * Q_BINS_MAX;
  localparam int AW = $clog2(N);
  localparam logic [COORD_W:0] I_MAX = (COORD_W+1)'(I_BINS_MAX);
  localparam logic [COORD_W:0] Q_MAX = (COORD_W+1)'(Q_BINS_MAX);
  localparam logic [COORD_W:0] ONE = (COORD_W+1)'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {INIT, ACCUM, DRAIN, STREAM} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] mem [N];
  logic [CNT_W-1:0] rd, inc, wr_data;
  logic [AW-1:0] init_cnt, p1_addr, p2_addr, s1_addr, rd_addr, wr_addr;
  logic [COORD_W-1:0] si, sq, s1_i, s1_q;
  logic [COORD_W:0] i_eff, q_eff;
  logic p1_v, p2_v, s1_v, s1_last, wr_en, drn, tail, scan_done, issue, i_wrap, q_wrap, empty;

  function automatic logic [AW-1:0] addr_of(input logic [COORD_W-1:0] i, input logic [COORD_W-1:0] q);
    return AW'(32'(q) * 32'(I_BINS_MAX) + 32'(i));
  endfunction

  always_comb begin
    i_eff = ({1'b0, i_bin_num} > I_MAX) ? I_MAX : {1'b0, i_bin_num};
    q_eff = ({1'b0, q_bin_num} > Q_MAX) ? Q_MAX : {1'b0, q_bin_num};
    empty = (i_eff == '0) || (q_eff == '0);
    i_wrap = {1'b0, si} == i_eff - ONE;
    q_wrap = {1'b0, sq} == q_eff - ONE;
    issue = (state == STREAM) && !scan_done && !empty;
    rd_addr = (state == STREAM) ? addr_of(si, sq) : p1_addr;
    inc = (rd == CNT_MAX) ? rd : rd + CNT_W'(1);
    wr_en = p2_v || (s1_v && CLEAR_ON_READ != 0) || (state == INIT);
    wr_addr = p2_v ? p2_addr : s1_v ? s1_addr : init_cnt;
    wr_data = p2_v ? inc : '0;
    busy = state != ACCUM;
    nxt = (state == INIT)  ? ((init_cnt == AW'(N - 1)) ? ACCUM : INIT)
        : (state == ACCUM) ? (start_data_out ? DRAIN : ACCUM)
        : (state == DRAIN) ? (drn ? STREAM : DRAIN)
        : ((last_out || tail) ? ACCUM : STREAM);
  end

  always_ff @(posedge clk100) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd <= (wr_en && wr_addr == rd_addr) ? wr_data : mem[rd_addr];
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) state <= INIT;
    else state <= nxt;
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      init_cnt  <= '0;
      drn       <= 1'b0;
      tail      <= 1'b0;
      p1_v      <= 1'b0;
      p1_addr   <= '0;
      p2_v      <= 1'b0;
      p2_addr   <= '0;
      si        <= '0;
      sq        <= '0;
      scan_done <= 1'b0;
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_i      <= '0;
      s1_q      <= '0;
      s1_addr   <= '0;
      data_out  <= 1'b0;
      last_out  <= 1'b0;
      bin_val   <= '0;
      i_bin_out <= '0;
      q_bin_out <= '0;
      drop_cnt  <= '0;
      sat_flag  <= 1'b0;
    end else begin
      init_cnt <= (state == INIT) ? init_cnt + AW'(1) : '0;
      drn <= (state == DRAIN) && !drn;
      tail <= (state == STREAM) && empty && !tail;
      p1_v <= (state == ACCUM) && data_in && ({1'b0, i_bin_coord} < i_eff) && ({1'b0, q_bin_coord} < q_eff);
      p1_addr <= addr_of(i_bin_coord, q_bin_coord);
      p2_v <= p1_v;
      p2_addr <= p1_addr;
      if (state != STREAM) begin
        si <= '0;
        sq <= '0;
        scan_done <= 1'b0;
      end else if (issue) begin
        si <= i_wrap ? '0 : si + COORD_W'(1);
        sq <= i_wrap ? sq + COORD_W'(1) : sq;
        scan_done <= i_wrap && q_wrap;
      end
      s1_v <= issue;
      s1_last <= i_wrap && q_wrap;
      s1_i <= si;
      s1_q <= sq;
      s1_addr <= rd_addr;
      data_out <= s1_v;
      last_out <= s1_v && s1_last;
      if (s1_v) begin
        bin_val <= rd;
        i_bin_out <= s1_i;
        q_bin_out <= s1_q;
      end
      if (data_in && state != ACCUM && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (p2_v && rd == CNT_MAX) sat_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_hist2d_accum_stream.sv
// tb_hist2d_accum_stream: directed and random checks of two histogram configurations against an array model
module tb_hist2d_accum_stream;
  logic clk100 = 1'b0;
  logic rst = 1'b1;
  logic data_in = 1'b0;
  logic start_data_out = 1'b0;
  logic [7:0] i_bin_coord = '0;
  logic [7:0] q_bin_coord = '0;
  logic [7:0] i_bin_num = 8'd10;
  logic [7:0] q_bin_num = 8'd10;
  logic a_do, a_last, a_busy, a_sat, b_do, b_last, b_busy, b_sat;
  logic [15:0] a_val, a_drop, b_drop;
  logic [3:0] b_val;
  logic [7:0] a_i, a_q, b_i, b_q;
  int compared = 0;
  int mismatched = 0;
  int ma [256];
  int mb [256];
  bit sa, sb;
  int drop_exp = 0;

  always #5 clk100 = ~clk100;

  hist2d_accum_stream u_a (
    .clk100(clk100), .rst(rst), .data_in(data_in), .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .start_data_out(start_data_out), .data_out(a_do),
    .bin_val(a_val), .i_bin_out(a_i), .q_bin_out(a_q), .last_out(a_last), .busy(a_busy),
    .drop_cnt(a_drop), .sat_flag(a_sat)
  );

  hist2d_accum_stream #(.CNT_W(4), .CLEAR_ON_READ(0)) u_b (
    .clk100(clk100), .rst(rst), .data_in(data_in), .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .start_data_out(start_data_out), .data_out(b_do),
    .bin_val(b_val), .i_bin_out(b_i), .q_bin_out(b_q), .last_out(b_last), .busy(b_busy),
    .drop_cnt(b_drop), .sat_flag(b_sat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int n);
    return n < 16 ? n : 16;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 256; k++) begin
      ma[k] = 0;
      mb[k] = 0;
    end
    sa = 0;
    sb = 0;
    drop_exp = 0;
  endtask

  task automatic check_reset();
    check("a_rst_do", a_do, 0);
    check("b_rst_do", b_do, 0);
    check("a_rst_last", a_last, 0);
    check("a_rst_val", a_val, 0);
    check("b_rst_val", b_val, 0);
    check("a_rst_i", a_i, 0);
    check("a_rst_q", a_q, 0);
    check("a_rst_busy", a_busy, 1);
    check("b_rst_busy", b_busy, 1);
    check("a_rst_drop", a_drop, 0);
    check("a_rst_sat", a_sat, 0);
    check("b_rst_sat", b_sat, 0);
  endtask

  task automatic status();
    repeat (3) @(negedge clk100);
    check("a_sat", a_sat, sa);
    check("b_sat", b_sat, sb);
    check("a_drop", a_drop, drop_exp);
    check("b_drop", b_drop, drop_exp);
  endtask

  task automatic init_wait(input bit pulse);
    rst = 1'b0;
    data_in = pulse;
    i_bin_coord = '0;
    q_bin_coord = '0;
    @(negedge clk100);
    data_in = 1'b0;
    if (pulse) drop_exp++;
    repeat (254) @(negedge clk100);
    check("a_busy_init", a_busy, 1);
    check("b_busy_init", b_busy, 1);
    @(negedge clk100);
    check("a_busy_ready", a_busy, 0);
    check("b_busy_ready", b_busy, 0);
    check("a_drop_init", a_drop, drop_exp);
  endtask

  task automatic hit(input int i, input int q, input int gap);
    data_in = 1'b1;
    i_bin_coord = 8'(i);
    q_bin_coord = 8'(q);
    @(negedge clk100);
    data_in = 1'b0;
    if (i < eff(int'(i_bin_num)) && q < eff(int'(q_bin_num))) begin
      if (ma[q*16+i] == 65535) sa = 1; else ma[q*16+i]++;
      if (mb[q*16+i] == 15) sb = 1; else mb[q*16+i]++;
    end
    repeat (gap) @(negedge clk100);
  endtask

  task automatic stream(input int ndrop);
    int ie, qe, n, j, idx, last_a, last_b, drops;
    ie = eff(int'(i_bin_num));
    qe = eff(int'(q_bin_num));
    n = ie * qe;
    drops = 0;
    last_a = 0;
    last_b = 0;
    start_data_out = 1'b1;
    @(negedge clk100);
    start_data_out = 1'b0;
    check("a_busy_start", a_busy, 1);
    check("b_busy_start", b_busy, 1);
    for (int m = 1; m <= n + 6; m++) begin
      @(negedge clk100);
      data_in = 1'b0;
      j = m - 4;
      if (j >= 0 && j < n) begin
        idx = (j / ie) * 16 + j % ie;
        check("a_do", a_do, 1);
        check("b_do", b_do, 1);
        check("a_i", a_i, j % ie);
        check("a_q", a_q, j / ie);
        check("b_i", b_i, j % ie);
        check("b_q", b_q, j / ie);
        check("a_val", a_val, ma[idx]);
        check("b_val", b_val, mb[idx]);
        check("a_last", a_last, j == n - 1);
        check("b_last", b_last, j == n - 1);
        last_a = ma[idx];
        last_b = mb[idx];
        ma[idx] = 0;
      end else begin
        check("a_do_idle", a_do, 0);
        check("b_do_idle", b_do, 0);
        check("a_last_idle", a_last, 0);
      end
      check("a_busy", a_busy, m < 4 + n);
      check("b_busy", b_busy, m < 4 + n);
      if (drops < ndrop && m >= 4 && m % 2 == 0) begin
        data_in = 1'b1;
        i_bin_coord = 8'd1;
        q_bin_coord = 8'd0;
        drops++;
        drop_exp++;
      end
    end
    if (n > 0) begin
      check("a_hold", a_val, last_a);
      check("b_hold", b_val, last_b);
    end
    check("a_drop_stream", a_drop, drop_exp);
    check("b_drop_stream", b_drop, drop_exp);
  endtask

  initial begin
    repeat (3) @(negedge clk100);
    check_reset();
    init_wait(1'b1);
    hit(0, 0, 5);
    hit(2, 1, 5);
    hit(4, 2, 5);
    hit(6, 3, 5);
    stream(0);
    repeat (5) hit(3, 3, 0);
    hit(1, 0, 0);
    hit(3, 3, 0);
    hit(1, 0, 0);
    hit(3, 3, 0);
    stream(3);
    i_bin_num = 8'd12;
    q_bin_num = 8'd9;
    for (int k = 0; k < 150; k++)
      hit(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), int'($urandom_range(0, 2)));
    status();
    stream(0);
    i_bin_num = 8'd10;
    q_bin_num = 8'd10;
    repeat (20) hit(0, 0, 0);
    status();
    stream(0);
    stream(0);
    hit(10, 2, 1);
    hit(2, 10, 1);
    hit(5, 5, 1);
    status();
    stream(0);
    i_bin_num = 8'd40;
    q_bin_num = 8'd2;
    hit(15, 1, 0);
    hit(20, 0, 0);
    hit(12, 0, 2);
    stream(0);
    i_bin_num = 8'd0;
    q_bin_num = 8'd10;
    hit(0, 0, 2);
    stream(0);
    status();
    i_bin_num = 8'd10;
    q_bin_num = 8'd10;
    hit(7, 3, 2);
    start_data_out = 1'b1;
    @(negedge clk100);
    start_data_out = 1'b0;
    for (int m = 1; m <= 41; m++) @(negedge clk100);
    check("a_do_bin37", a_do, 1);
    check("a_i_bin37", a_i, 7);
    check("a_q_bin37", a_q, 3);
    check("a_val_bin37", a_val, ma[3*16+7]);
    rst = 1'b1;
    #1;
    check_reset();
    model_clear();
    @(negedge clk100);
    init_wait(1'b0);
    i_bin_num = 8'd16;
    q_bin_num = 8'd16;
    stream(0);
    status();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
